// File: rtl/ecc_scalar_mult.sv
// Scalar multiplier Q = k*P by left-to-right double-and-add. Field arithmetic is
// delegated to external point-doubling and point-addition units via start/done handshakes.
module ecc_scalar_mult #(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] px,
  input  logic [n-1:0] py,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] qx,
  output logic [n-1:0] qy,
  output logic         q_inf,
  output logic         dbl_start,
  output logic [n-1:0] dbl_x,
  output logic [n-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic [n-1:0] dbl_x3,
  input  logic [n-1:0] dbl_y3,
  input  logic         dbl_inf,
  output logic         add_start,
  output logic [n-1:0] add_x1,
  output logic [n-1:0] add_y1,
  output logic [n-1:0] add_x2,
  output logic [n-1:0] add_y2,
  input  logic         add_done,
  input  logic [n-1:0] add_x3,
  input  logic [n-1:0] add_y3,
  input  logic         add_inf
);
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    SCAN     = 4'd2,
    DBL_REQ  = 4'd3,
    DBL_WAIT = 4'd4,
    ADD_REQ  = 4'd5,
    ADD_WAIT = 4'd6,
    NEXT     = 4'd7,
    FIN      = 4'd8
  } state_t;

  state_t        state_r, state_next_s;
  logic [n-1:0]  k_r, px_r, py_r;
  logic [n-1:0]  rx_r, ry_r, rx_next_s, ry_next_s;
  logic          rinf_r, rinf_next_s;
  logic          fold_r, fold_next_s;
  logic [IW-1:0] i_r, i_next_s;
  logic [n-1:0]  neg_py_s, dbl_x_s, dbl_y_s;
  logic          dbl_issue_s, add_issue_s;
  logic          busy_r, done_r, q_inf_r, dbl_start_r, add_start_r;
  logic [n-1:0]  qx_r, qy_r, dbl_x_r, dbl_y_r;
  logic [n-1:0]  add_x1_r, add_y1_r, add_x2_r, add_y2_r;
  logic          unused_s;

  // The coefficient a only matters to the doubling unit; it is not used here.
  assign unused_s = ^a;
  assign neg_py_s = (py_r == '0) ? '0 : (p - py_r);

  // Next-state and accumulator update logic.
  always_comb begin
    state_next_s = state_r;
    rx_next_s    = rx_r;
    ry_next_s    = ry_r;
    rinf_next_s  = rinf_r;
    i_next_s     = i_r;
    fold_next_s  = fold_r;
    dbl_issue_s  = 1'b0;
    dbl_x_s      = rx_r;
    dbl_y_s      = ry_r;
    add_issue_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          i_next_s     = IW'(n - 1);
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        rinf_next_s  = 1'b1;
        fold_next_s  = 1'b0;
        state_next_s = SCAN;
      end
      SCAN: begin
        if (k_r[i_r]) begin
          rx_next_s    = px_r;
          ry_next_s    = py_r;
          rinf_next_s  = 1'b0;
          state_next_s = NEXT;
        end else if (i_r == '0) begin
          rinf_next_s  = 1'b1;
          state_next_s = FIN;
        end else begin
          i_next_s = i_r - 1'b1;
        end
      end
      NEXT: begin
        if (i_r == '0) begin
          state_next_s = FIN;
        end else begin
          i_next_s     = i_r - 1'b1;
          state_next_s = DBL_REQ;
        end
      end
      DBL_REQ: begin
        // Doubling infinity or a point with y=0 gives infinity without the unit.
        if (rinf_r || (ry_r == '0)) begin
          rinf_next_s  = 1'b1;
          state_next_s = k_r[i_r] ? ADD_REQ : NEXT;
        end else begin
          dbl_issue_s  = 1'b1;
          state_next_s = DBL_WAIT;
        end
      end
      DBL_WAIT: begin
        if (dbl_done) begin
          rx_next_s   = dbl_x3;
          ry_next_s   = dbl_y3;
          rinf_next_s = dbl_inf;
          fold_next_s = 1'b0;
          if (fold_r) begin
            state_next_s = NEXT;
          end else begin
            state_next_s = k_r[i_r] ? ADD_REQ : NEXT;
          end
        end else begin
          state_next_s = DBL_WAIT;
        end
      end
      ADD_REQ: begin
        if (rinf_r) begin
          rx_next_s    = px_r;
          ry_next_s    = py_r;
          rinf_next_s  = 1'b0;
          state_next_s = NEXT;
        end else if ((rx_r == px_r) && (ry_r == py_r)) begin
          // R == P: the addition unit cannot handle it, so fold into a doubling.
          if (py_r == '0) begin
            rinf_next_s  = 1'b1;
            state_next_s = NEXT;
          end else begin
            dbl_issue_s  = 1'b1;
            dbl_x_s      = px_r;
            dbl_y_s      = py_r;
            fold_next_s  = 1'b1;
            state_next_s = DBL_WAIT;
          end
        end else if ((rx_r == px_r) && (ry_r == neg_py_s)) begin
          rinf_next_s  = 1'b1;
          state_next_s = NEXT;
        end else begin
          add_issue_s  = 1'b1;
          state_next_s = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        if (add_done) begin
          rx_next_s    = add_x3;
          ry_next_s    = add_y3;
          rinf_next_s  = add_inf;
          state_next_s = NEXT;
        end else begin
          state_next_s = ADD_WAIT;
        end
      end
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand latches, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      k_r         <= '0;
      px_r        <= '0;
      py_r        <= '0;
      rx_r        <= '0;
      ry_r        <= '0;
      rinf_r      <= 1'b1;
      fold_r      <= 1'b0;
      i_r         <= IW'(n - 1);
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      qx_r        <= '0;
      qy_r        <= '0;
      q_inf_r     <= 1'b0;
      dbl_start_r <= 1'b0;
      dbl_x_r     <= '0;
      dbl_y_r     <= '0;
      add_start_r <= 1'b0;
      add_x1_r    <= '0;
      add_y1_r    <= '0;
      add_x2_r    <= '0;
      add_y2_r    <= '0;
    end else begin
      state_r <= state_next_s;
      rx_r    <= rx_next_s;
      ry_r    <= ry_next_s;
      rinf_r  <= rinf_next_s;
      fold_r  <= fold_next_s;
      i_r     <= i_next_s;
      if ((state_r == IDLE) && start) begin
        k_r  <= k;
        px_r <= px;
        py_r <= py;
      end
      busy_r      <= (state_next_s != IDLE) && (state_next_s != FIN);
      done_r      <= (state_next_s == FIN);
      dbl_start_r <= dbl_issue_s;
      add_start_r <= add_issue_s;
      if ((state_next_s == FIN) && (state_r != FIN)) begin
        qx_r    <= rinf_next_s ? '0 : rx_next_s;
        qy_r    <= rinf_next_s ? '0 : ry_next_s;
        q_inf_r <= rinf_next_s;
      end
      if (dbl_issue_s) begin
        dbl_x_r <= dbl_x_s;
        dbl_y_r <= dbl_y_s;
      end
      if (add_issue_s) begin
        add_x1_r <= rx_r;
        add_y1_r <= ry_r;
        add_x2_r <= px_r;
        add_y2_r <= py_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign qx        = qx_r;
  assign qy        = qy_r;
  assign q_inf     = q_inf_r;
  assign dbl_start = dbl_start_r;
  assign dbl_x     = dbl_x_r;
  assign dbl_y     = dbl_y_r;
  assign add_start = add_start_r;
  assign add_x1    = add_x1_r;
  assign add_y1    = add_y1_r;
  assign add_x2    = add_x2_r;
  assign add_y2    = add_y2_r;

endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Directed bench for ecc_scalar_mult on y^2 = x^3 + 2x + 2 over GF(17), P=(5,1), order 19,
// with behavioural point-doubling/addition units answering after 1-20 cycles.
module tb_ecc_scalar_mult;
  localparam int N  = 8;
  localparam int PR = 17;
  localparam int AC = 2;

  logic         clk, reset, start;
  logic [N-1:0] k, px, py, p, a;
  logic         busy, done, q_inf;
  logic [N-1:0] qx, qy;
  logic         dbl_start, dbl_done, dbl_inf;
  logic [N-1:0] dbl_x, dbl_y, dbl_x3, dbl_y3;
  logic         add_start, add_done, add_inf;
  logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;

  int n_checks = 0;
  int n_pass   = 0;
  int n_dbl    = 0;
  int n_add    = 0;
  int stab_err = 0;
  int stray_req  = 0;
  int stray_seen = 0;

  ecc_scalar_mult #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py), .p(p), .a(a),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y),
    .dbl_done(dbl_done), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3), .dbl_inf(dbl_inf),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2), .add_y2(add_y2),
    .add_done(add_done), .add_x3(add_x3), .add_y3(add_y3), .add_inf(add_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int md(input int v);
    return ((v % PR) + PR) % PR;
  endfunction

  function automatic int minv(input int v);
    int r = 1;
    int b = md(v);
    for (int e = 0; e < PR - 2; e++) r = md(r * b);
    return r;
  endfunction

  task automatic ec_dbl(input int x, input int y, output int x3, output int y3, output bit inf);
    int lam;
    if (y == 0) begin x3 = 0; y3 = 0; inf = 1'b1; end
    else begin
      lam = md((3 * x * x + AC) * minv(2 * y));
      x3  = md(lam * lam - 2 * x);
      y3  = md(lam * (x - x3) - y);
      inf = 1'b0;
    end
  endtask

  task automatic ec_add(input int x1, input int y1, input int x2, input int y2,
                        output int x3, output int y3, output bit inf);
    int lam;
    if (x1 == x2) begin
      if (y1 == y2) ec_dbl(x1, y1, x3, y3, inf);
      else begin x3 = 0; y3 = 0; inf = 1'b1; end
    end else begin
      lam = md((y2 - y1) * minv(x2 - x1));
      x3  = md(lam * lam - x1 - x2);
      y3  = md(lam * (x1 - x3) - y1);
      inf = 1'b0;
    end
  endtask

  // Behavioural units plus stray-response injector; sole driver of the unit result inputs.
  initial begin
    int dcd, acd, cdx, cdy, cax1, cay1, cax2, cay2, rx3, ry3;
    bit rinf;
    dcd = 0; acd = 0; cdx = 0; cdy = 0; cax1 = 0; cay1 = 0; cax2 = 0; cay2 = 0;
    dbl_done = 1'b0; dbl_x3 = '0; dbl_y3 = '0; dbl_inf = 1'b0;
    add_done = 1'b0; add_x3 = '0; add_y3 = '0; add_inf = 1'b0;
    forever begin
      @(posedge clk); #1;
      dbl_done = 1'b0;
      add_done = 1'b0;
      if (dcd > 0) begin
        if (int'(dbl_x) != cdx || int'(dbl_y) != cdy) stab_err++;
        dcd--;
        if (dcd == 0) begin
          ec_dbl(cdx, cdy, rx3, ry3, rinf);
          dbl_x3 = N'(rx3); dbl_y3 = N'(ry3); dbl_inf = rinf; dbl_done = 1'b1;
        end
      end
      if (acd > 0) begin
        if (int'(add_x1) != cax1 || int'(add_y1) != cay1 ||
            int'(add_x2) != cax2 || int'(add_y2) != cay2) stab_err++;
        acd--;
        if (acd == 0) begin
          ec_add(cax1, cay1, cax2, cay2, rx3, ry3, rinf);
          add_x3 = N'(rx3); add_y3 = N'(ry3); add_inf = rinf; add_done = 1'b1;
        end
      end
      if (dbl_start === 1'b1) begin
        n_dbl++;
        cdx = int'(dbl_x); cdy = int'(dbl_y);
        dcd = int'($urandom_range(20, 1));
      end
      if (add_start === 1'b1) begin
        n_add++;
        cax1 = int'(add_x1); cay1 = int'(add_y1); cax2 = int'(add_x2); cay2 = int'(add_y2);
        acd = int'($urandom_range(20, 1));
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        dbl_x3 = 8'd13; dbl_y3 = 8'd7; dbl_inf = 1'b1; dbl_done = 1'b1;
      end
    end
  end

  task automatic run_op(input logic [N-1:0] kv, output logic [N-1:0] rx, output logic [N-1:0] ry,
                        output logic rinf, output int cyc);
    @(negedge clk); k = kv; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    rx = qx; ry = qy; rinf = q_inf;
    n_checks++;
    if (done !== 1'b1) $display("FAIL done_timeout k=%0d: done=%b after %0d cycles, want 1", kv, done, cyc);
    else n_pass++;
  endtask

  task automatic check_point(input string name, input logic [N-1:0] rx, input logic [N-1:0] ry,
                             input logic rinf, input logic [N-1:0] ex, input logic [N-1:0] ey,
                             input logic einf);
    n_checks++;
    if (rx !== ex || ry !== ey || rinf !== einf)
      $display("FAIL %s: got (%0d,%0d,inf=%b), want (%0d,%0d,inf=%b)", name, rx, ry, rinf, ex, ey, einf);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; k = '0;
    px = 8'd5; py = 8'd1; p = 8'd17; a = 8'd2;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, q_inf, dbl_start, add_start} !== 5'b00000)
      $display("FAIL reset_ctrl: busy/done/q_inf/dbl_start/add_start=%b, want 00000",
               {busy, done, q_inf, dbl_start, add_start});
    else n_pass++;
    n_checks++;
    if ({qx, qy, dbl_x, dbl_y, add_x1, add_y2} !== 48'd0)
      $display("FAIL reset_data: qx=%0d qy=%0d dbl_x=%0d add_x1=%0d, want all 0", qx, qy, dbl_x, add_x1);
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_small_k;
    logic [N-1:0] rx, ry; logic rinf; int cyc, d0, a0, s0;
    d0 = n_dbl; a0 = n_add; s0 = stab_err;
    run_op(8'd2, rx, ry, rinf, cyc);
    check_point("k2_result", rx, ry, rinf, 8'd6, 8'd3, 1'b0);
    n_checks++;
    if (n_dbl - d0 != 1 || n_add - a0 != 0)
      $display("FAIL k2_requests: dbl=%0d add=%0d, want 1 0", n_dbl - d0, n_add - a0);
    else n_pass++;
    d0 = n_dbl; a0 = n_add;
    run_op(8'd3, rx, ry, rinf, cyc);
    check_point("k3_result", rx, ry, rinf, 8'd10, 8'd6, 1'b0);
    n_checks++;
    if (n_dbl - d0 != 1 || n_add - a0 != 1)
      $display("FAIL k3_requests: dbl=%0d add=%0d, want 1 1", n_dbl - d0, n_add - a0);
    else n_pass++;
    n_checks++;
    if (stab_err != s0) $display("FAIL operand_stability: %0d changes in WAIT, want 0", stab_err - s0);
    else n_pass++;
  endtask

  task automatic test_zero_k;
    logic [N-1:0] rx, ry; logic rinf; int cyc, d0, a0;
    d0 = n_dbl; a0 = n_add;
    run_op(8'd0, rx, ry, rinf, cyc);
    check_point("k0_result", rx, ry, rinf, 8'd0, 8'd0, 1'b1);
    n_checks++;
    if (n_dbl != d0 || n_add != a0 || cyc != N + 2)
      $display("FAIL k0_timing: dbl=%0d add=%0d latency=%0d, want 0 0 %0d", n_dbl - d0, n_add - a0, cyc, N + 2);
    else n_pass++;
  endtask

  task automatic test_special_cases;
    logic [N-1:0] rx, ry; logic rinf; int cyc, d0, a0;
    run_op(8'd19, rx, ry, rinf, cyc);
    check_point("k19_order", rx, ry, rinf, 8'd0, 8'd0, 1'b1);
    run_op(8'd18, rx, ry, rinf, cyc);
    check_point("k18_neg", rx, ry, rinf, 8'd5, 8'd16, 1'b0);
    d0 = n_dbl; a0 = n_add;
    run_op(8'd21, rx, ry, rinf, cyc);
    check_point("k21_fold", rx, ry, rinf, 8'd6, 8'd3, 1'b0);
    n_checks++;
    if (n_dbl - d0 != 5 || n_add - a0 != 1)
      $display("FAIL k21_requests: dbl=%0d add=%0d, want 5 1", n_dbl - d0, n_add - a0);
    else n_pass++;
    run_op(8'd9, rx, ry, rinf, cyc);
    check_point("k9_result", rx, ry, rinf, 8'd7, 8'd6, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] rx, ry; logic rinf; int cyc, d0; bit seen; bit saw_done;
    seen = 1'b0; saw_done = 1'b0;
    @(negedge clk); k = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (dbl_start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL mid_dbl_start: dbl_start=0 within 50 cycles, want 1");
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, q_inf, dbl_start, add_start} !== 5'b00000 || {qx, qy, dbl_x, dbl_y} !== 32'd0)
      $display("FAIL mid_reset_outputs: ctrl=%b qx=%0d qy=%0d dbl_x=%0d dbl_y=%0d, want all 0",
               {busy, done, q_inf, dbl_start, add_start}, qx, qy, dbl_x, dbl_y);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d0 = n_dbl;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done || n_dbl != d0)
      $display("FAIL mid_no_activity: done/busy seen=%b new dbl=%0d, want 0 0", saw_done, n_dbl - d0);
    else n_pass++;
    run_op(8'd2, rx, ry, rinf, cyc);
    check_point("after_reset_k2", rx, ry, rinf, 8'd6, 8'd3, 1'b0);
  endtask

  task automatic test_ignored_inputs;
    bit seen; int cyc;
    seen = 1'b0;
    @(negedge clk); k = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    k = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (add_start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL ign_add_start: add_start=0 within 200 cycles, want 1");
    else n_pass++;
    stray_req++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check_point("ign_result", qx, qy, q_inf, 8'd10, 8'd6, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ign_no_restart: busy=%b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] rx, ry; logic rinf; int cyc;
    run_op(8'd2, rx, ry, rinf, cyc);
    k = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_start_at_done: busy=%b, want 0", busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    check_point("b2b_hold", qx, qy, q_inf, 8'd6, 8'd3, 1'b0);
    run_op(8'd3, rx, ry, rinf, cyc);
    check_point("b2b_k3", rx, ry, rinf, 8'd10, 8'd6, 1'b0);
  endtask

  initial begin
    test_reset;
    test_small_k;
    test_zero_k;
    test_special_cases;
    test_reset_mid;
    test_ignored_inputs;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
